sprite_mover: RTL and testbench
===============================

# sprite_mover

- Frame-synchronous motion controller that owns a sprite's on-screen position.
- Produces `loc_h`/`loc_v` for the downstream pixel-address generator, which maps `h_cnt`/`v_cnt` and the sprite location to a ROM address and wraps horizontally at 850 columns.
- Position changes only on `frame_tick`, so a frame is never scanned with a half-updated location.
- Horizontal motion wraps modulo `H_TOTAL`; vertical motion is clamped (or bounces, see Configuration) inside the visible area.

## Interface
Parameters:
- `H_TOTAL`, 850, horizontal wrap modulus; must match the address generator's wrap column.
- `V_LIMIT`, 480, visible lines.
- `HEIGHT`, 90, sprite height in lines; `V_MAX = V_LIMIT - HEIGHT` (390).
- `INIT_H`, 0, reset/home column.
- `INIT_V`, 0, reset/home line.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame (start of vblank).
- `start` in 1: pulse; begin or resume motion.
- `stop` in 1: pulse; pause motion.
- `home` in 1: pulse; return to `INIT_H`/`INIT_V` and idle.
- `dir_left` in 1: level; 1 = move left, 0 = move right.
- `v_dir` in 2: 01 = down, 10 = up, 00/11 = none.
- `speed_h` in 4: pixels per frame, horizontal; 0 = no horizontal motion.
- `speed_v` in 4: lines per frame, vertical; 0 = no vertical motion.
- `loc_h` out 10: registered sprite column, always in 0..`H_TOTAL`-1.
- `loc_v` out 10: registered sprite line, always in 0..`V_MAX`.
- `running` out 1: high in state RUN.
- `wrapped` out 1: one-cycle pulse on a tick where the horizontal position crossed the wrap point.
- `v_edge` out 1: one-cycle pulse on a tick where the vertical position hit 0 or `V_MAX`.

## Operation
- States:
  - IDLE: reset and home state.
  - RUN: sprite moves on each tick.
  - HOLD: paused; position frozen.
- Transitions, in priority order `home` > `stop` > `start`:
  - `home` in any state -> IDLE; `loc_h`/`loc_v` reloaded to `INIT_H`/`INIT_V`.
  - `stop` in RUN -> HOLD; in IDLE or HOLD it has no effect.
  - `start` in IDLE or HOLD -> RUN; in RUN it has no effect.
- Move condition: state is RUN, `frame_tick`=1, and neither `stop` nor `home` is asserted in the same cycle.
- Horizontal step, using an 11-bit intermediate:
  - Right: `s = loc_h + speed_h`; if `s >= H_TOTAL` then `loc_h = s - H_TOTAL` and `wrapped` pulses.
  - Left: if `loc_h >= speed_h` then `loc_h = loc_h - speed_h`; otherwise `loc_h = loc_h + H_TOTAL - speed_h` and `wrapped` pulses.
- Vertical step:
  - Down: `loc_v = min(loc_v + speed_v, V_MAX)`.
  - Up: `loc_v = max(loc_v - speed_v, 0)`, computed without underflow.
  - `v_edge` pulses when the result equals the boundary in the direction of travel and `speed_v` != 0.
- `dir_left`, `v_dir` and speeds are sampled live on every move cycle.

## Timing
- Reset values: `loc_h`=`INIT_H`, `loc_v`=`INIT_V`, state IDLE, `running`=0, `wrapped`=0, `v_edge`=0.
- Latency:
  - Position updates on the clock edge that samples a qualifying `frame_tick`; new `loc_*` is visible the following cycle.
  - `wrapped` and `v_edge` are asserted in that same following cycle, for exactly one cycle.
- `start` together with `frame_tick`: the state becomes RUN but no move happens on that tick; the first move is on the next tick.
- `stop` or `home` together with `frame_tick`: no move; the state transition applies.
- `running` is registered from the state and changes one cycle after the command.
- `rst` asserted mid-frame forces all reset values immediately (asynchronous); outputs stay at reset values until the first edge after `rst` deasserts.

## Configuration
- `SPRITE_VBOUNCE_EN` defined:
  - An internal vertical-direction register is loaded from `v_dir` on `start`.
  - The register inverts when a boundary is reached, so the next tick moves away from the edge.
  - `v_dir` is ignored while in RUN.
- `SPRITE_VBOUNCE_EN` undefined:
  - Vertical motion clamps at the boundary.
  - `v_dir` is sampled live.

## Test plan
- Reset -> `loc_h`=0, `loc_v`=0, `running`=0; `start`, `dir_left`=0, `speed_h`=5, then 3 ticks -> `loc_h`=15, `running`=1.
- From `loc_h`=0: `dir_left`=1, `speed_h`=2, 1 tick -> `loc_h`=848 with `wrapped` pulse; then `dir_left`=0, `speed_h`=5, 1 tick -> `loc_h`=3 with `wrapped` pulse.
- `loc_v`=388, `v_dir`=01, `speed_v`=4, 1 tick -> `loc_v`=390 with `v_edge`. Next tick gives `loc_v`=390 without the macro, or `loc_v`=386 with `SPRITE_VBOUNCE_EN`.
- `start` and `frame_tick` in the same cycle -> `loc_h` unchanged; next tick moves by `speed_h`.
- In RUN at `loc_h`=100: `stop` with tick -> no move, HOLD; two more ticks -> still 100; `home` -> `loc_h`=0, IDLE.
- `rst` pulsed mid-run at `loc_h`=200 -> `loc_h`=0 with no clock edge required.

Source files
------------

// File: rtl/sprite_mover.sv
// sprite_mover: frame-synchronous sprite position controller.
// Horizontal position wraps modulo H_TOTAL. Vertical position is clamped
// to 0..V_LIMIT-HEIGHT, or bounces off the edges when SPRITE_VBOUNCE_EN is
// defined at compile time.
module sprite_mover #(
    parameter int unsigned H_TOTAL = 850,
    parameter int unsigned V_LIMIT = 480,
    parameter int unsigned HEIGHT  = 90,
    parameter int unsigned INIT_H  = 0,
    parameter int unsigned INIT_V  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       home,
    input  logic       dir_left,
    input  logic [1:0] v_dir,
    input  logic [3:0] speed_h,
    input  logic [3:0] speed_v,
    output logic [9:0] loc_h,
    output logic [9:0] loc_v,
    output logic       running,
    output logic       wrapped,
    output logic       v_edge
);

    localparam int unsigned V_MAX   = V_LIMIT - HEIGHT;
    localparam logic [10:0] H_TOT11 = 11'(H_TOTAL);
    localparam logic [10:0] V_MAX11 = 11'(V_MAX);
    localparam logic [9:0]  V_MAX10 = 10'(V_MAX);
    localparam logic [9:0]  HOME_H  = 10'(INIT_H);
    localparam logic [9:0]  HOME_V  = 10'(INIT_V);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [9:0]  loc_h_q, loc_h_d, loc_v_q, loc_v_d;
    logic        running_q, wrapped_q, wrapped_d, v_edge_q, v_edge_d;
    logic        move;
    logic [1:0]  vdir_eff;
    logic [10:0] sum_h_r, sum_h_l, sum_v;
    logic [9:0]  step_h, step_v;
    logic        step_wrap, step_edge;

`ifdef SPRITE_VBOUNCE_EN
    logic [1:0] vdir_q, vdir_d;
    assign vdir_eff = vdir_q;
`else
    assign vdir_eff = v_dir;
`endif

    // A move happens only on a tick in RUN that is not overridden by a command.
    assign move = (state_q == RUN) && frame_tick && !stop && !home;

    // Candidate horizontal position for this tick, with wrap detection.
    always_comb begin
        sum_h_r   = {1'b0, loc_h_q} + {7'b0, speed_h};
        sum_h_l   = {1'b0, loc_h_q} + H_TOT11 - {7'b0, speed_h};
        step_h    = loc_h_q;
        step_wrap = 1'b0;
        if (!dir_left) begin
            if (sum_h_r >= H_TOT11) begin
                step_h    = 10'(sum_h_r - H_TOT11);
                step_wrap = 1'b1;
            end else begin
                step_h = sum_h_r[9:0];
            end
        end else begin
            if (loc_h_q >= {6'b0, speed_h}) begin
                step_h = loc_h_q - {6'b0, speed_h};
            end else begin
                step_h    = sum_h_l[9:0];
                step_wrap = 1'b1;
            end
        end
    end

    // Candidate vertical position for this tick, clamped to the visible area.
    always_comb begin
        sum_v     = {1'b0, loc_v_q} + {7'b0, speed_v};
        step_v    = loc_v_q;
        step_edge = 1'b0;
        if (vdir_eff == 2'b01) begin
            if (sum_v >= V_MAX11) begin
                step_v    = V_MAX10;
                step_edge = (speed_v != 4'd0);
            end else begin
                step_v = sum_v[9:0];
            end
        end else if (vdir_eff == 2'b10) begin
            if ({6'b0, speed_v} >= loc_v_q) begin
                step_v    = '0;
                step_edge = (speed_v != 4'd0);
            end else begin
                step_v = loc_v_q - {6'b0, speed_v};
            end
        end
    end

    // Next state and next outputs; home > stop > start priority.
    always_comb begin
        state_d   = state_q;
        loc_h_d   = loc_h_q;
        loc_v_d   = loc_v_q;
        wrapped_d = 1'b0;
        v_edge_d  = 1'b0;
`ifdef SPRITE_VBOUNCE_EN
        vdir_d    = vdir_q;
`endif
        if (home) begin
            state_d = IDLE;
            loc_h_d = HOME_H;
            loc_v_d = HOME_V;
        end else if (stop) begin
            if (state_q == RUN) state_d = HOLD;
        end else if (start && state_q != RUN) begin
            state_d = RUN;
`ifdef SPRITE_VBOUNCE_EN
            vdir_d  = v_dir;
`endif
        end else if (move) begin
            loc_h_d   = step_h;
            loc_v_d   = step_v;
            wrapped_d = step_wrap;
            v_edge_d  = step_edge;
`ifdef SPRITE_VBOUNCE_EN
            // Reverse only on an actual edge hit so the next tick leaves the edge.
            if (step_edge) vdir_d = (vdir_q == 2'b01) ? 2'b10 : 2'b01;
`endif
        end
    end

    // State, position and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            loc_h_q   <= HOME_H;
            loc_v_q   <= HOME_V;
            running_q <= 1'b0;
            wrapped_q <= 1'b0;
            v_edge_q  <= 1'b0;
`ifdef SPRITE_VBOUNCE_EN
            vdir_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            loc_h_q   <= loc_h_d;
            loc_v_q   <= loc_v_d;
            running_q <= (state_d == RUN);
            wrapped_q <= wrapped_d;
            v_edge_q  <= v_edge_d;
`ifdef SPRITE_VBOUNCE_EN
            vdir_q    <= vdir_d;
`endif
        end
    end

    assign loc_h   = loc_h_q;
    assign loc_v   = loc_v_q;
    assign running = running_q;
    assign wrapped = wrapped_q;
    assign v_edge  = v_edge_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Testbench for sprite_mover: directed stimulus, behavioural position model
// checked every cycle, plus literal expectations from hand calculation.
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0, start = 1'b0, stop = 1'b0, home = 1'b0;
    logic       dir_left = 1'b0;
    logic [1:0] v_dir = 2'b00;
    logic [3:0] speed_h = 4'd0, speed_v = 4'd0;
    logic [9:0] loc_h, loc_v;
    logic       running, wrapped, v_edge;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 idle, 1 moving, 2 paused.
    int m_mode = 0, m_h = 0, m_v = 0, m_run = 0, m_wrap = 0, m_edge = 0, m_vdir = 0;

    sprite_mover #(.H_TOTAL(850), .V_LIMIT(480), .HEIGHT(90), .INIT_H(0), .INIT_V(0)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .stop(stop),
        .home(home), .dir_left(dir_left), .v_dir(v_dir), .speed_h(speed_h),
        .speed_v(speed_v), .loc_h(loc_h), .loc_v(loc_v), .running(running),
        .wrapped(wrapped), .v_edge(v_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_v = 0; m_run = 0; m_wrap = 0; m_edge = 0; m_vdir = 0;
    endtask

    // Apply one clock edge worth of behaviour using the inputs just sampled.
    task automatic model_step();
        int d, nv;
        m_wrap = 0;
        m_edge = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (home) begin
            m_mode = 0; m_h = 0; m_v = 0;
        end else if (stop) begin
            if (m_mode == 1) m_mode = 2;
        end else if (start && m_mode != 1) begin
            m_mode = 1;
            m_vdir = int'(v_dir);
        end else if (m_mode == 1 && frame_tick) begin
`ifdef SPRITE_VBOUNCE_EN
            d = m_vdir;
`else
            d = int'(v_dir);
`endif
            if (!dir_left) begin
                m_wrap = (m_h + int'(speed_h) >= 850) ? 1 : 0;
                m_h = (m_h + int'(speed_h)) % 850;
            end else begin
                m_wrap = (int'(speed_h) > m_h) ? 1 : 0;
                m_h = (m_h - int'(speed_h) + 850) % 850;
            end
            if (d == 1) begin
                nv = m_v + int'(speed_v);
                if (nv > 390) nv = 390;
                m_edge = (speed_v != 0 && nv == 390) ? 1 : 0;
                m_v = nv;
            end else if (d == 2) begin
                nv = m_v - int'(speed_v);
                if (nv < 0) nv = 0;
                m_edge = (speed_v != 0 && nv == 0) ? 1 : 0;
                m_v = nv;
            end
`ifdef SPRITE_VBOUNCE_EN
            if (m_edge == 1) m_vdir = 3 - d;
`endif
        end
        m_run = (m_mode == 1) ? 1 : 0;
    endtask

    // One clock cycle with the given command pulses.
    task automatic cyc(input logic ft, input logic st, input logic sp, input logic hm);
        frame_tick = ft; start = st; stop = sp; home = hm;
        @(posedge clk);
        model_step();
        @(negedge clk);
        frame_tick = 1'b0; start = 1'b0; stop = 1'b0; home = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Every cycle, outputs must match the model.
    always @(negedge clk) begin
        check("loc_h", int'(loc_h), m_h);
        check("loc_v", int'(loc_v), m_v);
        check("running", int'(running), m_run);
        check("wrapped", int'(wrapped), m_wrap);
        check("v_edge", int'(v_edge), m_edge);
    end

    initial begin
        model_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_loc_h", int'(loc_h), 0);
        check("rst_loc_v", int'(loc_v), 0);
        check("rst_running", int'(running), 0);

        // Right motion at 5 px/frame.
        dir_left = 1'b0; speed_h = 4'd5;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        check("right3_loc_h", int'(loc_h), 15);
        check("right3_running", int'(running), 1);

        // Left wrap from 0, then right wrap back past 849.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("home_running", int'(running), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        dir_left = 1'b1; speed_h = 4'd2;
        tick();
        check("lwrap_loc_h", int'(loc_h), 848);
        check("lwrap_pulse", int'(wrapped), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("lwrap_one_cycle", int'(wrapped), 0);
        dir_left = 1'b0; speed_h = 4'd5;
        tick();
        check("rwrap_loc_h", int'(loc_h), 3);
        check("rwrap_pulse", int'(wrapped), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // start together with a tick: no move on that tick.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("start_tick_no_move", int'(loc_h), 0);
        ticks(1);
        check("start_tick_next_move", int'(loc_h), 5);

        // Vertical: approach the bottom limit.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        speed_h = 4'd0; v_dir = 2'b01; speed_v = 4'd12;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(32);
        check("down_384", int'(loc_v), 384);
        speed_v = 4'd4;
        tick();
        check("down_388", int'(loc_v), 388);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("down_clamp_390", int'(loc_v), 390);
        check("down_edge", int'(v_edge), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef SPRITE_VBOUNCE_EN
        check("after_edge", int'(loc_v), 386);
`else
        check("after_edge", int'(loc_v), 390);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Vertical: upward to the top limit, including clamp at 0.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        v_dir = 2'b10; speed_v = 4'd15;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(28);

        // Mixed horizontal patterns, checked by the model each cycle.
        dir_left = 1'b1; speed_h = 4'd15; v_dir = 2'b00;
        ticks(60);
        dir_left = 1'b0; speed_h = 4'd13;
        ticks(70);

        // stop with tick at column 100, hold, then home.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        dir_left = 1'b0; speed_h = 4'd10; speed_v = 4'd0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check("run_to_100", int'(loc_h), 100);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("stop_tick_no_move", int'(loc_h), 100);
        check("stop_running", int'(running), 0);
        ticks(2);
        check("hold_frozen", int'(loc_h), 100);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("home_loc_h", int'(loc_h), 0);
        check("home_idle", int'(running), 0);

        // Asynchronous reset mid-run at column 200.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("run_to_200", int'(loc_h), 200);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_loc_h", int'(loc_h), 0);
        check("async_rst_running", int'(running), 0);
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        check("post_rst_move", int'(loc_h), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
